// File: rtl/sw_playback_ctrl_pkg.sv
// Shared types for the switch-capture playback sequencer.
// State encodings are also used by the bench's reference model.
package sw_playback_ctrl_pkg;

  localparam int STATE_W = 2;
  localparam int CNT_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  // Counter width that stays legal for a divide-by-one.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_playback_ctrl_tick_gen.sv
// Playback step timer: one-cycle tick every TICK_DIV enabled cycles.
// Counter is forced to zero whenever en_i is low.
module tick_gen
  import sw_playback_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = cw(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick_o  = en_i && at_last;

  always_comb begin
    cnt_d = '0;
    if (en_i && !at_last) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sw_playback_ctrl.sv
// Records switch words into a small buffer and replays them
// onto the LEDs at a fixed step rate.
module sw_playback_ctrl
  import sw_playback_ctrl_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rec_i,
  input  logic              play_i,
  input  logic [DATA_W-1:0] sw_i,
  output logic [DATA_W-1:0] led_o,
  output logic [3:0]        cnt_o,
  output logic [3:0]        idx_o,
  output logic [1:0]        state_o,
  output logic              full_o,
  output logic              busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic              full_q, full_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     rd_nxt;
  logic              tick;
  logic              tick_en;

  assign rd_nxt  = idx_q[AW-1:0] + AW'(1);
  // Abort edge also clears the timer so IDLE always sees zero.
  assign tick_en = (state_q == ST_PLAY) && !play_i;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    led_d   = led_q;
    we      = 1'b0;
    waddr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (play_i) begin
          if (cnt_q != '0) begin
            state_d = ST_PLAY;
            idx_d   = '0;
            led_d   = mem_q[0];
          end
        end else if (rec_i && cnt_q < DEPTH_C) begin
          we    = 1'b1;
          waddr = cnt_q[AW-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          led_d = sw_i;
        end
      end
      ST_PLAY: begin
        if (play_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (tick) begin
          if (idx_q == cnt_q - CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + CNT_W'(1);
            led_d = mem_q[rd_nxt];
          end
        end
      end
      ST_DONE: begin
        if (play_i) begin
          state_d = ST_PLAY;
          idx_d   = '0;
          led_d   = mem_q[0];
        end else if (rec_i) begin
          we      = 1'b1;
          waddr   = '0;
          cnt_d   = CNT_W'(1);
          led_d   = sw_i;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    full_d = (cnt_d == DEPTH_C);
    busy_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      led_q   <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= sw_i;
  end

  assign led_o   = led_q;
  assign cnt_o   = cnt_q;
  assign idx_o   = idx_q;
  assign state_o = state_q;
  assign full_o  = full_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_sw_playback_ctrl.sv
// Bench for sw_playback_ctrl: vector table, directed corners,
// and random pulses checked against a queue-based model.
module tb_sw_playback_ctrl;
  import sw_playback_ctrl_pkg::*;

  localparam int DW = 10;
  localparam int DEP = 8;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rec = 1'b0;
  logic play = 1'b0;
  logic [DW-1:0] sw = '0;
  logic [DW-1:0] led;
  logic [3:0] cnt, idx;
  logic [1:0] st;
  logic full, busy;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: captured words in a queue, playback position
  // derived from cycles elapsed since PLAY entry.
  int m_buf[$];
  int m_st, m_idx, m_led, m_el;

  typedef struct {
    logic r;
    logic p;
    int   s;
    int   cnt;
    int   led;
    int   st;
    int   idx;
  } vec_t;

  vec_t tbl[17];

  sw_playback_ctrl #(
    .DATA_W(DW), .DEPTH(DEP), .TICK_DIV(TD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rec_i(rec), .play_i(play),
    .sw_i(sw), .led_o(led), .cnt_o(cnt), .idx_o(idx),
    .state_o(st), .full_o(full), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_buf.delete();
    m_st = 0; m_idx = 0; m_led = 0; m_el = 0;
  endtask

  task automatic m_start();
    m_st = 1; m_idx = 0; m_led = m_buf[0]; m_el = 0;
  endtask

  task automatic m_step(input logic r, input logic p, input int s);
    case (m_st)
      0: begin
        if (p) begin
          if (m_buf.size() > 0) m_start();
        end else if (r && m_buf.size() < DEP) begin
          m_buf.push_back(s);
          m_led = s;
        end
      end
      1: begin
        if (p) begin
          m_st = 0; m_idx = 0;
        end else begin
          m_el++;
          if (m_el % TD == 0) begin
            if (m_idx == m_buf.size() - 1) m_st = 2;
            else begin
              m_idx++;
              m_led = m_buf[m_idx];
            end
          end
        end
      end
      default: begin
        if (p) m_start();
        else if (r) begin
          m_buf.delete();
          m_buf.push_back(s);
          m_led = s; m_idx = 0; m_st = 0;
        end
      end
    endcase
  endtask

  task automatic m_check();
    chk("led", int'(led), m_led);
    chk("cnt", int'(cnt), m_buf.size());
    chk("idx", int'(idx), m_idx);
    chk("state", int'(st), m_st);
    chk("full", int'(full), int'(m_buf.size() == DEP));
    chk("busy", int'(busy), int'(m_st == 1));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cyc(input logic r, input logic p, input int s);
    rec = r; play = p; sw = DW'(s);
    @(posedge clk);
    m_step(r, p, s);
    @(negedge clk);
    rec = 1'b0; play = 1'b0;
    m_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
    chk("rst_led", int'(led), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_state", int'(st), int'(ST_IDLE));
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  task automatic set_v(input int i, input logic r, input logic p,
                       input int s, input int c, input int l,
                       input int t, input int x);
    tbl[i].r = r; tbl[i].p = p; tbl[i].s = s;
    tbl[i].cnt = c; tbl[i].led = l; tbl[i].st = t; tbl[i].idx = x;
  endtask

  initial begin
    set_v(0, 1, 0, 'h155, 1, 'h155, 0, 0);
    set_v(1, 1, 0, 'h2AA, 2, 'h2AA, 0, 0);
    set_v(2, 1, 0, 'h0F0, 3, 'h0F0, 0, 0);
    set_v(3, 0, 1, 0, 3, 'h155, 1, 0);
    for (int i = 4; i < 7; i++) set_v(i, 0, 0, 0, 3, 'h155, 1, 0);
    for (int i = 7; i < 11; i++) set_v(i, 0, 0, 0, 3, 'h2AA, 1, 1);
    for (int i = 11; i < 15; i++) set_v(i, 0, 0, 0, 3, 'h0F0, 1, 2);
    set_v(15, 0, 0, 0, 3, 'h0F0, 2, 2);
    set_v(16, 1, 0, 'h3FF, 1, 'h3FF, 0, 0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].r, tbl[i].p, tbl[i].s);
      chk($sformatf("v%0d_cnt", i), int'(cnt), tbl[i].cnt);
      chk($sformatf("v%0d_led", i), int'(led), tbl[i].led);
      chk($sformatf("v%0d_state", i), int'(st), tbl[i].st);
      chk($sformatf("v%0d_idx", i), int'(idx), tbl[i].idx);
      chk($sformatf("v%0d_full", i), int'(full), 0);
      chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].st == 1));
    end

    // play with an empty buffer does nothing
    do_reset();
    cyc(0, 1, 0);
    chk("empty_play_state", int'(st), 0);
    chk("empty_play_led", int'(led), 0);

    // overfill: ninth record dropped, playback never shows it
    for (int i = 1; i <= 9; i++) cyc(1, 0, i);
    chk("full_cnt", int'(cnt), 8);
    chk("full_flag", int'(full), 1);
    chk("full_led", int'(led), 8);
    cyc(0, 1, 0);
    for (int i = 0; i < DEP * TD + 2; i++) begin
      cyc(0, 0, 0);
      chk("no_nine", int'(led == 10'd9), 0);
    end
    chk("full_done", int'(st), 2);
    chk("full_done_led", int'(led), 8);

    // DONE with both pulses: play wins
    cyc(1, 1, 'h3FF);
    chk("done_both_state", int'(st), 1);
    chk("done_both_led", int'(led), 1);
    chk("done_both_cnt", int'(cnt), 8);

    // simultaneous pulses in IDLE, then abort at idx 1
    do_reset();
    cyc(1, 0, 'h011);
    cyc(1, 0, 'h022);
    cyc(1, 1, 'h033);
    chk("both_state", int'(st), 1);
    chk("both_cnt", int'(cnt), 2);
    for (int i = 0; i < TD; i++) cyc(0, 0, 0);
    chk("mid_idx", int'(idx), 1);
    cyc(0, 1, 0);
    chk("abort_state", int'(st), 0);
    chk("abort_led", int'(led), 'h022);
    chk("abort_idx", int'(idx), 0);
    chk("abort_cnt", int'(cnt), 2);

    // async reset between edges mid-PLAY
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(st), 0);
    chk("arst_led", int'(led), 0);
    chk("arst_cnt", int'(cnt), 0);
    chk("arst_idx", int'(idx), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_full", int'(full), 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();

    // random pulses against the model
    for (int i = 0; i < 1500; i++) begin
      int k;
      k = int'($urandom_range(0, 99));
      if (k < 18)      cyc(1, 0, int'($urandom_range(0, 1023)));
      else if (k < 26) cyc(0, 1, 0);
      else             cyc(0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_playback_ctrl.md
Name: sw_playback_ctrl

Overview:
Sequencer for the switch-capture datapath. Each debounced record pulse captures the 10-bit switch word into an 8-entry buffer. A play pulse then steps the captured words onto the LEDs at a fixed timed rate. Sits between the button debouncer outputs and the LED/hex drivers; cnt_o and idx_o feed the existing hex decoders.

Parameters:
DATA_W, 10, width of captured switch word
DEPTH, 8, buffer entries; legal values 2, 4, 8
TICK_DIV, 50_000_000, clk_i cycles per playback step (0.5 s at 100 MHz); bench uses 4

Ports:
clk_i    in   1        system clock, 100 MHz
rst_i    in   1        reset, asynchronous, active-high
rec_i    in   1        one-cycle record pulse from debouncer
play_i   in   1        one-cycle play/abort pulse from debouncer
sw_i     in   DATA_W   switch word to capture
led_o    out  DATA_W   displayed word, registered
cnt_o    out  4        number of captured entries, 0..DEPTH
idx_o    out  4        current playback index
state_o  out  2        0=IDLE, 1=PLAY, 2=DONE
full_o   out  1        cnt_o == DEPTH
busy_o   out  1        state_o == PLAY

Behaviour:
- Reset (async, rst_i=1): state=IDLE, led_o=0, cnt_o=0, idx_o=0, tick counter=0, full_o=0, busy_o=0. Buffer contents are don't-care.
- All outputs are registered. Each event takes effect on the clock edge where its pulse is high and is visible from the next cycle.
- IDLE:
  - rec_i with cnt<DEPTH: mem[cnt]<=sw_i, cnt<=cnt+1, led_o<=sw_i.
  - rec_i with cnt==DEPTH: ignored; full_o stays 1.
  - play_i with cnt>0: go to PLAY, idx<=0, led_o<=mem[0], tick counter cleared.
  - play_i with cnt==0: ignored.
  - rec_i and play_i in the same cycle: play wins, rec is dropped.
- PLAY:
  - Tick counter runs 0..TICK_DIV-1. The tick fires on the cycle the counter equals TICK_DIV-1, then the counter wraps to 0.
  - First tick arrives TICK_DIV cycles after PLAY entry.
  - On a tick with idx<cnt-1: idx<=idx+1, led_o<=mem[idx+1].
  - On a tick with idx==cnt-1: go to DONE; idx and led_o hold.
  - cnt==1: the first tick goes straight to DONE.
  - rec_i: ignored.
  - play_i: abort to IDLE; led_o holds its current value; idx<=0; cnt unchanged.
- DONE:
  - led_o holds the last entry.
  - play_i: restart PLAY from idx 0 (same as the IDLE entry).
  - rec_i: start a new recording. mem[0]<=sw_i, cnt<=1, led_o<=sw_i, idx<=0, go to IDLE.
  - Both pulses in the same cycle: play wins.
- Width rules: cnt is 4 bits and saturates at DEPTH. idx never exceeds cnt-1. Read index is idx[clog2(DEPTH)-1:0].
- Tick counter width: clog2(TICK_DIV). It is held at 0 outside PLAY.
- Reset asserted mid-PLAY: immediate return to the reset values listed above.
- state encoding 3 is unreachable; if entered, the next edge returns to IDLE.

Decomposition:
- Shared header: state encodings ST_IDLE/ST_PLAY/ST_DONE and the state width, shared with the top-level and the bench.
- One sub-module: tick_gen (parameter TICK_DIV; ports clk_i, rst_i, en_i, tick_o). Counter is cleared when en_i=0 and produces a one-cycle tick_o.
- Buffer: register array inside sw_playback_ctrl; no RAM macro.

Test Plan:
- Reset then record sw=0x155, 0x2AA, 0x0F0 -> cnt_o=3, led_o=0x0F0, state_o=0, full_o=0.
- Then play_i (TICK_DIV=4) -> led_o sequence 0x155, 0x2AA, 0x0F0, each step 4 cycles apart. state_o=2 after the third tick, idx_o=2, busy_o drops.
- 9 record pulses with DEPTH=8 (sw = 1..9) -> cnt_o=8, full_o=1, led_o=8; 9th ignored; playback never shows 9.
- play_i and rec_i in the same cycle in IDLE with cnt=2 -> enters PLAY, cnt_o stays 2. play_i again mid-PLAY at idx 1 -> IDLE, led_o holds mem[1].
- In DONE, rec_i with sw=0x3FF -> cnt_o=1, led_o=0x3FF, state_o=0. play_i with cnt=0 after reset -> no change.
- rst_i pulsed asynchronously between clock edges mid-PLAY -> all outputs 0 before the next edge; state_o=0.
